// File: rtl/accel_display_pkg.sv
// Shared types and sizing helpers for the accelerometer display path.
package accel_display_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_e;

   // Decimal digits needed for a WIDTH-bit magnitude: ceil(width * log10(2)), 77/256 ~ log10(2).
   function automatic int unsigned int_digits(input int unsigned width);
      return (width * 32'd77 + 32'd255) / 32'd256;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Sample-in / BCD-out bundle between the accelerometer front end and hex_driver.
interface bin_to_bcd_seq_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned NUM_DIGITS = 6
);
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   logic                    out_valid;
   logic [4*NUM_DIGITS-1:0] bcd_digits;
   logic                    negative;
   logic                    overflow;

   modport master (
      output in_valid, in_data,
      input  in_ready, out_valid, bcd_digits, negative, overflow
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out_valid, bcd_digits, negative, overflow
   );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 ahead of the next shift.
module bcd_add3
   import accel_display_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout_c
);
   assign dout_c = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: signed sample -> NUM_DIGITS BCD digits + sign, one shift per clock.
module bin_to_bcd_seq
   import accel_display_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned NUM_DIGITS = 6
) (
   input  logic           clk,
   input  logic           reset,
   bin_to_bcd_seq_if.slave bus
);
   localparam int unsigned INT_DIGITS = int_digits(WIDTH);
   localparam int unsigned SCR_W      = 4 * INT_DIGITS;
   localparam int unsigned OUT_W      = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W      = $clog2(WIDTH + 1);

   conv_state_e      state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mag;
   logic [SCR_W-1:0] scratch;
   logic [SCR_W-1:0] scratch_adj_c;
   logic             neg_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [OUT_W-1:0] digits_r;
   logic             negative_r;
   logic             overflow_r;

   logic             accept_c;
   logic             last_shift_c;
   logic [OUT_W-1:0] digits_raw_c;
   logic [OUT_W-1:0] digits_c;
   logic             ovf_c;
   logic             unused_msb_c;

   assign accept_c     = bus.in_valid & in_ready_r;
   assign last_shift_c = (cnt == CNT_W'(WIDTH - 1));
   // Top scratch bit is always shifted out as zero: INT_DIGITS is sized to hold any magnitude.
   assign unused_msb_c = scratch_adj_c[SCR_W-1];

   for (genvar k = 0; k < INT_DIGITS; k++) begin : g_add3
      bcd_add3 u_add3 (
         .din    (scratch[4*k +: 4]),
         .dout_c (scratch_adj_c[4*k +: 4])
      );
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_out
      if (k < INT_DIGITS) begin : g_live
         assign digits_raw_c[4*k +: 4] = scratch[4*k +: 4];
      end else begin : g_pad
         assign digits_raw_c[4*k +: 4] = 4'd0;
      end
   end

   // Saturate when the magnitude needs more digits than the display shows.
   if (INT_DIGITS > NUM_DIGITS) begin : g_ovf
      assign ovf_c = |scratch[SCR_W-1:OUT_W];
   end else begin : g_no_ovf
      assign ovf_c = 1'b0;
   end

   assign digits_c = ovf_c ? {NUM_DIGITS{4'h9}} : digits_raw_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_c) state_next = SHIFT;
         SHIFT:   if (last_shift_c) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs, sequenced by the current state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         mag         <= '0;
         scratch     <= '0;
         neg_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         digits_r    <= '0;
         negative_r  <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         in_ready_r  <= (state_next == IDLE);
         case (state)
            IDLE: begin
               if (accept_c) begin
                  neg_r   <= bus.in_data[WIDTH-1];
                  mag     <= bus.in_data[WIDTH-1] ? WIDTH'(-bus.in_data) : bus.in_data;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               scratch <= {scratch_adj_c[SCR_W-2:0], mag[WIDTH-1]};
               mag     <= {mag[WIDTH-2:0], 1'b0};
               cnt     <= cnt + CNT_W'(1);
            end
            DONE: begin
               out_valid_r <= 1'b1;
               digits_r    <= digits_c;
               overflow_r  <= ovf_c;
               negative_r  <= neg_r;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.bcd_digits = digits_r;
   assign bus.negative   = negative_r;
   assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 6-digit instance plus a 4-digit instance for saturation.
module tb_bin_to_bcd_seq;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.WIDTH(16), .NUM_DIGITS(6)) if6 ();
   bin_to_bcd_seq_if #(.WIDTH(16), .NUM_DIGITS(4)) if4 ();

   bin_to_bcd_seq #(.WIDTH(16), .NUM_DIGITS(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if6.slave)
   );

   bin_to_bcd_seq #(.WIDTH(16), .NUM_DIGITS(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Push one sample into the 6-digit converter and check latency, result and strobe width.
   task automatic convert6(input string tag, input logic [15:0] data,
                           input logic [23:0] exp_d, input logic exp_neg);
      int  edges;
      bit  seen;
      @(negedge clk);
      if6.in_valid = 1'b1;
      if6.in_data  = data;
      check({tag, "_ready"}, 32'(if6.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if6.in_valid = 1'b0;
      edges = 0;
      seen  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if6.out_valid) seen = 1'b1;
      end
      check({tag, "_latency"}, 32'(edges), 32'd17);
      check({tag, "_digits"},  32'(if6.bcd_digits), 32'(exp_d));
      check({tag, "_neg"},     32'(if6.negative), 32'(exp_neg));
      check({tag, "_ovf"},     32'(if6.overflow), 32'd0);
      @(negedge clk);
      check({tag, "_strobe"},  32'(if6.out_valid), 32'd0);
   endtask

   initial begin
      logic [23:0] res [2];
      int          acc_cyc [2];
      int          n_acc;
      int          n_res;
      int          cyc;
      int          edges;
      int          strobes;
      bit          seen;

      if6.in_valid = 1'b0;
      if6.in_data  = '0;
      if4.in_valid = 1'b0;
      if4.in_data  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready",  32'(if6.in_ready), 32'd1);
      check("rst_valid",  32'(if6.out_valid), 32'd0);
      check("rst_digits", 32'(if6.bcd_digits), 32'd0);
      reset = 1'b0;

      convert6("pos12345", 16'd12345, 24'h012345, 1'b0);
      convert6("min_neg",  16'h8000,  24'h032768, 1'b1);
      convert6("minus1",   16'hFFFF,  24'h000001, 1'b1);
      convert6("zero",     16'd0,     24'h000000, 1'b0);
      convert6("max_pos",  16'd32767, 24'h032767, 1'b0);

      // Reset while idle with a nonzero result held on the outputs.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("idle_rst_ready",  32'(if6.in_ready), 32'd1);
      check("idle_rst_valid",  32'(if6.out_valid), 32'd0);
      check("idle_rst_digits", 32'(if6.bcd_digits), 32'd0);
      check("idle_rst_neg",    32'(if6.negative), 32'd0);
      check("idle_rst_ovf",    32'(if6.overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Back-to-back: in_valid stays high across two samples.
      @(negedge clk);
      if6.in_valid = 1'b1;
      if6.in_data  = 16'd100;
      n_acc = 0;
      n_res = 0;
      cyc   = 0;
      for (int i = 0; i < 50; i++) begin
         if (i != 0) @(negedge clk);
         if (if6.out_valid) begin
            if (n_res < 2) res[n_res] = if6.bcd_digits;
            n_res++;
         end
         if (n_acc == 1) if6.in_data = 16'd200;
         if (n_acc == 2) if6.in_valid = 1'b0;
         if (if6.in_valid && if6.in_ready) begin
            if (n_acc < 2) acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         @(posedge clk);
         cyc++;
      end
      check("b2b_accepts", 32'(n_acc), 32'd2);
      check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
      check("b2b_strobes", 32'(n_res), 32'd2);
      check("b2b_res0",    32'(res[0]), 32'h000100);
      check("b2b_res1",    32'(res[1]), 32'h000200);

      // Four-digit instance saturates a five-digit magnitude.
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.in_data  = 16'd12345;
      @(posedge clk);
      @(negedge clk);
      if4.in_valid = 1'b0;
      edges = 0;
      seen  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (if4.out_valid) seen = 1'b1;
      end
      check("sat_latency", 32'(edges), 32'd17);
      check("sat_digits",  32'(if4.bcd_digits), 32'h9999);
      check("sat_ovf",     32'(if4.overflow), 32'd1);
      check("sat_neg",     32'(if4.negative), 32'd0);

      // Abandon a conversion with reset after its seventh shift.
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.in_data  = 16'd999;
      @(posedge clk);
      @(negedge clk);
      if4.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("mid_busy", 32'(if4.in_ready), 32'd0);
      reset = 1'b1;
      #1;
      check("mid_rst_ready",  32'(if4.in_ready), 32'd1);
      check("mid_rst_digits", 32'(if4.bcd_digits), 32'd0);
      check("mid_rst_ovf",    32'(if4.overflow), 32'd0);
      check("mid_rst_neg",    32'(if4.negative), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      strobes = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (if4.out_valid) strobes++;
      end
      check("mid_no_strobe", 32'(strobes), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
